// File: rtl/unidade_acesso_memoria.sv
// Multicycle load/store unit: sized/extended loads, read-modify-write byte and
// halfword stores, alignment checking, start/busy/done handshake.
module unidade_acesso_memoria #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_LW  = 3'd0, OP_LB  = 3'd1, OP_LH  = 3'd2, OP_SH  = 3'd3,
    OP_SB  = 3'd4, OP_SW  = 3'd5, OP_LBU = 3'd6, OP_LHU = 3'd7
  } op_e;

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       ld_q, ld_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  op_e               op_in;

  assign op_in = op_e'(op);

  function automatic logic misaligned(input op_e o, input logic [1:0] a);
    case (o)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input op_e o);
    return (o == OP_LW) || (o == OP_LB) || (o == OP_LH) ||
           (o == OP_LBU) || (o == OP_LHU);
  endfunction

  function automatic logic [31:0] extend(input op_e o, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (o)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input op_e o, input logic [1:0] a,
                                        input logic [31:0] w, input logic [15:0] s);
    logic [31:0] r;
    r = w;
    if (o == OP_SB)      r[{a, 3'b000} +: 8]     = s[7:0];
    else if (o == OP_SH) r[{a[1], 4'b0000} +: 16] = s;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_in;
          lane_d  = addr[1:0];
          sdata_d = store_data[15:0];
          maddr_d = {addr[ADDR_W-1:2], 2'b00};
          if (misaligned(op_in, addr[1:0])) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (op_in == OP_SW) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = store_data;
          end else begin
            state_d = S_READ;
            re_d    = 1'b1;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 2'd0) begin
          // Outputs are registered, so the extended/merged word is computed
          // straight from mem_rdata on the capturing edge.
          if (is_load(op_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ld_d    = extend(op_q, lane_q, mem_rdata);
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = merge(op_q, lane_q, mem_rdata, sdata_q);
          end
        end else begin
          cnt_d = 2'(cnt_q - 2'd1);
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        maddr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      lane_q  <= '0;
      sdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      maddr_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      sdata_q <= sdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      maddr_q <= maddr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = ld_q;
  assign mem_addr  = maddr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/unidade_acesso_memoria.md
# unidade_acesso_memoria

Sequential load/store access unit for the multicycle CPU datapath. It sits between the control unit and the word-wide data memory. It performs word, halfword and byte loads with sign or zero extension, and halfword and byte stores by read-modify-write. It also detects misaligned accesses and handshakes with the control unit through start/busy/done. It is the successor to the combinational size-selection logic and adds unsigned loads, a configurable memory read latency and alignment checking.

## Interface
- READ_LAT, 1: data memory read latency in cycles, legal range 1..4.
- ADDR_W, 32: byte address width.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  000 LW, 001 LB, 010 LH, 011 SH, 100 SB, 101 SW, 110 LBU, 111 LHU.
- addr  in  ADDR_W  byte address of the access.
- store_data  in  32  store operand; uses bits [7:0] for SB, [15:0] for SH, all 32 bits for SW.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned flag; valid together with done.
- load_data  out  32  extended load result; holds its value until the next load completes.
- mem_addr  out  ADDR_W  word address: {addr[ADDR_W-1:2], 2'b00}.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid READ_LAT cycles after mem_re.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start=1: register op, addr and store_data, then branch:
  - Misaligned access → DONE with err=1. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - SW → WRITE.
  - All other ops → READ.
- READ:
  - mem_re=1 in the first READ cycle only.
  - The state lasts exactly READ_LAT cycles.
  - mem_rdata is captured on the edge that ends the last READ cycle.
  - Loads then go to DONE; SB/SH go to WRITE.
- WRITE: one cycle with mem_we=1, then DONE.
  - SW: mem_wdata = store_data.
  - SB: replaces byte lane addr[1:0] of the captured word with store_data[7:0].
  - SH: replaces halfword lane addr[1] of the captured word with store_data[15:0].
- DONE: done=1 for one cycle, then IDLE.
- Lane order is little-endian: byte k = bits [8k+7:8k], halfword h = bits [16h+15:16h].
- Load extension:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: pass the word through unchanged.
- load_data updates only on completion of a load that has err=0.
- Stores and errored operations leave load_data unchanged.
- Misaligned operations never assert mem_re or mem_we.
- start outside IDLE is ignored, including during the DONE cycle; no queueing.
- mem_addr is driven from the registered address whenever busy=1, and is 0 in IDLE.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE.
- Load: READ during cycles 1..READ_LAT; done in cycle READ_LAT+1. load_data is valid from that cycle on.
- SW: WRITE in cycle 1, done in cycle 2.
- SB/SH: READ during cycles 1..READ_LAT, WRITE in cycle READ_LAT+1, done in cycle READ_LAT+2.
- Misaligned access: done=1 and err=1 in cycle 1.
- busy=1 from cycle 1 through the DONE cycle. The earliest next accepted start is the cycle after DONE.
- Reset values (asynchronous, take effect immediately): state IDLE; busy, done, err, mem_re and mem_we 0; mem_addr, mem_wdata and load_data 0.
- Reset mid-operation aborts the access with no done pulse. A pending mem_we drops immediately and no partial write is issued after reset releases.
- All outputs are registered, except busy, which decodes the state register directly.

## Test plan
- Memory word 0x8765_43A1 at 0x100, READ_LAT=1:
  - LB at 0x100 → 0xFFFF_FFA1.
  - LBU at 0x100 → 0x0000_00A1.
  - LB at 0x101 → 0x0000_0043.
  - Each has done in cycle 2.
- Same word, READ_LAT=3:
  - LH at 0x102 → 0xFFFF_8765, done in cycle 4.
  - LHU at 0x102 → 0x0000_8765.
  - LW at 0x100 → 0x8765_43A1.
- SB at 0x103, store_data=0x1234_56FF, READ_LAT=2 → mem_re in cycle 1, mem_we in cycle 3 with mem_wdata=0xFF65_43A1 and mem_addr=0x100, done in cycle 4.
- SH at 0x101, and SW at 0x102 → done=1 and err=1 in cycle 1; mem_re and mem_we stay 0; load_data unchanged.
- SW at 0x104 with store_data=0xDEAD_BEEF → mem_we in cycle 1 with mem_wdata=0xDEAD_BEEF; a start pulsed in cycles 1 and 2 is ignored; a start in cycle 3 is accepted.
- SB issued, reset asserted during READ → busy=0 and all strobes 0 immediately; no mem_we and no done afterwards; a following LW completes normally.
